// File: rtl/branch_resolve_predict.sv
// -----------------------------------------------------------------------------
// branch_resolve_predict
//
// Resolves B-type branch direction from funct3 and the external comparator
// result, trains a direct-mapped table of 2-bit saturating counters with the
// resolved outcome, and serves registered taken/not-taken predictions to fetch.
//
// Parameters
//   BHT_ENTRIES  table depth (power of two, >= 2); index = pc[IDXW+1:2]
//   PC_WIDTH     width of fetch_pc / res_pc
//
// Ports
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   fetch_valid/pc  lookup request
//   pred_valid      registered fetch_valid
//   pred_taken      registered counter MSB of looked-up entry
//   res_valid/pc    resolving branch in execute
//   res_funct3      branch condition select
//   res_pred_taken  prediction fetch used for this branch
//   br_un           combinational unsigned-compare select to comparator
//   br_eq, br_lt    comparator results
//   res_taken       registered resolved direction
//   mispredict      registered one-cycle pulse on direction mismatch
//   illegal         registered one-cycle pulse on funct3 010/011
//
// Build option
//   BP_BYPASS_EN    when defined, a same-cycle lookup of the entry being
//                   updated returns the post-update counter MSB; otherwise
//                   the lookup sees the pre-update value.
// -----------------------------------------------------------------------------
module branch_resolve_predict #(
   parameter int unsigned BHT_ENTRIES = 32,
   parameter int unsigned PC_WIDTH    = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                fetch_valid,
   input  logic [PC_WIDTH-1:0] fetch_pc,
   output logic                pred_valid,
   output logic                pred_taken,
   input  logic                res_valid,
   input  logic [PC_WIDTH-1:0] res_pc,
   input  logic [2:0]          res_funct3,
   input  logic                res_pred_taken,
   output logic                br_un,
   input  logic                br_eq,
   input  logic                br_lt,
   output logic                res_taken,
   output logic                mispredict,
   output logic                illegal
);

   localparam int unsigned IDXW = $clog2(BHT_ENTRIES);

   logic [1:0]      bht [BHT_ENTRIES];
   logic [IDXW-1:0] fetch_idx;
   logic [IDXW-1:0] res_idx;
   logic            res_legal;
   logic            res_dir;
   logic            upd_en;
   logic [1:0]      res_cnt;
   logic [1:0]      res_cnt_next;
   logic            lookup_msb;

   // PC bits outside the index field are intentionally ignored (no tags).
   logic unused_pc_bits;
   assign unused_pc_bits = ^{fetch_pc[PC_WIDTH-1:IDXW+2], fetch_pc[1:0],
                             res_pc[PC_WIDTH-1:IDXW+2], res_pc[1:0]};

   assign fetch_idx = fetch_pc[IDXW+1:2];
   assign res_idx   = res_pc[IDXW+1:2];

   // Comparator must settle within the resolve cycle, so no register here.
   assign br_un = res_funct3[1];

   always_comb begin
      res_legal = (res_funct3[2:1] != 2'b01);
      res_dir   = 1'b0;
      unique case (res_funct3)
         3'b000:  res_dir = br_eq;
         3'b001:  res_dir = ~br_eq;
         3'b100,
         3'b110:  res_dir = br_lt;
         3'b101,
         3'b111:  res_dir = ~br_lt;
         default: res_dir = 1'b0;
      endcase
   end

   assign upd_en  = res_valid & res_legal;
   assign res_cnt = bht[res_idx];

   always_comb begin
      res_cnt_next = res_cnt;
      if (res_dir) begin
         if (res_cnt != 2'b11) res_cnt_next = res_cnt + 2'd1;
      end else begin
         if (res_cnt != 2'b00) res_cnt_next = res_cnt - 2'd1;
      end
   end

`ifdef BP_BYPASS_EN
   always_comb begin
      lookup_msb = bht[fetch_idx][1];
      if (upd_en && (res_idx == fetch_idx)) lookup_msb = res_cnt_next[1];
   end
`else
   assign lookup_msb = bht[fetch_idx][1];
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bht        <= '{default: 2'b01};
         pred_valid <= 1'b0;
         pred_taken <= 1'b0;
         res_taken  <= 1'b0;
         mispredict <= 1'b0;
         illegal    <= 1'b0;
      end else begin
         if (upd_en) bht[res_idx] <= res_cnt_next;
         pred_valid <= fetch_valid;
         pred_taken <= fetch_valid & lookup_msb;
         res_taken  <= upd_en & res_dir;
         mispredict <= upd_en & (res_dir != res_pred_taken);
         illegal    <= res_valid & ~res_legal;
      end
   end

endmodule

// File: tb/tb_branch_resolve_predict.sv
module tb_branch_resolve_predict;

   localparam int unsigned BHT = 32;
   localparam int unsigned PCW = 32;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           fetch_valid;
   logic [PCW-1:0] fetch_pc;
   logic           pred_valid;
   logic           pred_taken;
   logic           res_valid;
   logic [PCW-1:0] res_pc;
   logic [2:0]     res_funct3;
   logic           res_pred_taken;
   logic           br_un;
   logic           br_eq;
   logic           br_lt;
   logic           res_taken;
   logic           mispredict;
   logic           illegal;

   // Small comparator driven by the DUT's br_un select.
   logic [3:0] op_a;
   logic [3:0] op_b;
   assign br_eq = (op_a == op_b);
   assign br_lt = br_un ? (op_a < op_b) : ($signed(op_a) < $signed(op_b));

   always #5 clk = ~clk;

   branch_resolve_predict #(
      .BHT_ENTRIES(BHT),
      .PC_WIDTH   (PCW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .fetch_valid   (fetch_valid),
      .fetch_pc      (fetch_pc),
      .pred_valid    (pred_valid),
      .pred_taken    (pred_taken),
      .res_valid     (res_valid),
      .res_pc        (res_pc),
      .res_funct3    (res_funct3),
      .res_pred_taken(res_pred_taken),
      .br_un         (br_un),
      .br_eq         (br_eq),
      .br_lt         (br_lt),
      .res_taken     (res_taken),
      .mispredict    (mispredict),
      .illegal       (illegal)
   );

   // Reference model: one integer 0..3 per table slot.
   int model_cnt [BHT];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Branch semantics from the ISA definition on the raw operands.
   function automatic bit ref_dir(input logic [2:0] f3, input logic [3:0] a, input logic [3:0] b);
      case (f3)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return $signed(a) < $signed(b);
         3'd5:    return !($signed(a) < $signed(b));
         3'd6:    return a < b;
         3'd7:    return !(a < b);
         default: return 1'b0;
      endcase
   endfunction

   function automatic int slot_of(input logic [31:0] pc);
      return int'((pc / 32'd4) % BHT);
   endfunction

   task automatic cycle(input bit rst, input bit fv, input logic [31:0] fpc,
                        input bit rv, input logic [31:0] rpc, input logic [2:0] f3,
                        input bit rpt, input logic [3:0] a, input logic [3:0] b);
      bit e_pv, e_pt, e_rt, e_mp, e_il, dir, legal;
      int fi, ri, newc;
      @(negedge clk);
      rst_n          = ~rst;
      fetch_valid    = fv;
      fetch_pc       = fpc;
      res_valid      = rv;
      res_pc         = rpc;
      res_funct3     = f3;
      res_pred_taken = rpt;
      op_a           = a;
      op_b           = b;
      #1;
      check_val("br_un", 32'(br_un), 32'((f3 == 3'd6) || (f3 == 3'd7) || (f3 == 3'd2) || (f3 == 3'd3)));
      @(posedge clk);
      e_pv = 0; e_pt = 0; e_rt = 0; e_mp = 0; e_il = 0;
      if (rst) begin
         for (int i = 0; i < int'(BHT); i++) model_cnt[i] = 1;
      end else begin
         fi    = slot_of(fpc);
         ri    = slot_of(rpc);
         legal = !(f3 == 3'd2 || f3 == 3'd3);
         dir   = ref_dir(f3, a, b);
         newc  = model_cnt[ri];
         if (rv && legal) newc = dir ? ((newc < 3) ? newc + 1 : 3) : ((newc > 0) ? newc - 1 : 0);
         e_pv = fv;
         e_pt = fv && (model_cnt[fi] >= 2);
`ifdef BP_BYPASS_EN
         if (fv && rv && legal && fi == ri) e_pt = (newc >= 2);
`endif
         e_rt = rv && legal && dir;
         e_mp = rv && legal && (dir != rpt);
         e_il = rv && !legal;
         if (rv && legal) model_cnt[ri] = newc;
      end
      #1;
      check_val("pred_valid", 32'(pred_valid), 32'(e_pv));
      check_val("pred_taken", 32'(pred_taken), 32'(e_pt));
      check_val("res_taken",  32'(res_taken),  32'(e_rt));
      check_val("mispredict", 32'(mispredict), 32'(e_mp));
      check_val("illegal",    32'(illegal),    32'(e_il));
   endtask

   initial begin
      rst_n = 0; fetch_valid = 0; fetch_pc = '0; res_valid = 0; res_pc = '0;
      res_funct3 = '0; res_pred_taken = 0; op_a = '0; op_b = '0;
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);

      // Directed walk-through of the key scenarios.
      cycle(0, 1, 'h100, 0, 0,      3'd0, 0, 0, 0);   // weakly not-taken
      cycle(0, 0, 0,     1, 'h100,  3'd0, 0, 3, 3);   // BEQ taken, mispredict
      cycle(0, 1, 'h100, 0, 0,      3'd0, 0, 0, 0);   // now predicts taken
      for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 'h100, 3'd0, 1, 7, 7);
      cycle(0, 0, 0,     1, 'h100,  3'd0, 1, 1, 2);   // not taken: 11 -> 10
      cycle(0, 1, 'h100, 0, 0,      3'd0, 0, 0, 0);
      cycle(0, 0, 0,     1, 'h40,   3'd6, 0, 9, 2);   // BLTU
      cycle(0, 0, 0,     1, 'h40,   3'd4, 0, 9, 2);   // BLT signed
      cycle(0, 0, 0,     1, 'h44,   3'd7, 0, 5, 3);   // BGEU, lt=0
      cycle(0, 0, 0,     1, 'h100,  3'd2, 1, 3, 3);   // illegal
      cycle(0, 1, 'h100, 1, 'h100,  3'd3, 0, 0, 0);   // illegal, counter intact
      cycle(0, 1, 'h200, 1, 'h200,  3'd0, 0, 4, 4);   // same-slot lookup+update
      cycle(0, 1, 'h200, 0, 0,      3'd0, 0, 0, 0);
      cycle(1, 1, 'h100, 1, 'h100,  3'd0, 0, 1, 1);   // reset wins
      cycle(0, 1, 'h100, 0, 0,      3'd0, 0, 0, 0);
      cycle(0, 1, 'h44,  0, 0,      3'd0, 0, 0, 0);

      // Randomized traffic with heavy index aliasing.
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] fpc, rpc;
         fpc = 32'($urandom_range(0, 47) * 4) | (32'($urandom_range(0, 1)) << 12);
         rpc = 32'($urandom_range(0, 47) * 4) | (32'($urandom_range(0, 1)) << 12);
         if ($urandom_range(0, 3) == 0) rpc = fpc;
         cycle($urandom_range(0, 199) == 0, 1'($urandom), fpc,
               1'($urandom), rpc, 3'($urandom), 1'($urandom),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
